// File: rtl/fp32_accum_sequencer.sv
// rtl/fp32_accum_sequencer.sv - stb/ack initiator reducing a run of FP32 elements through an external adder
// Optional build macro FP32_ACC_ZERO_SKIP_EN: +/-0 elements are consumed without an adder exchange.
module fp32_accum_sequencer #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic [31:0]        in_data,
  input  logic               in_stb,
  output logic               in_ack,
  output logic [31:0]        add_a,
  output logic               add_a_stb,
  input  logic               add_a_ack,
  output logic [31:0]        add_b,
  output logic               add_b_stb,
  input  logic               add_b_ack,
  input  logic [31:0]        add_z,
  input  logic               add_z_stb,
  output logic               add_z_ack,
  output logic [31:0]        result,
  output logic               result_stb,
  input  logic               result_ack,
  output logic               busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GET_X  = 3'd1;
  localparam logic [2:0] S_SEND_A = 3'd2;
  localparam logic [2:0] S_SEND_B = 3'd3;
  localparam logic [2:0] S_GET_Z  = 3'd4;
  localparam logic [2:0] S_PUT_R  = 3'd5;

  logic [2:0]         state;
  logic [31:0]        acc;
  logic [31:0]        x;
  logic [COUNT_W-1:0] cnt;
  logic               last;

  // cnt counts down to 1 rather than 0, so a full-scale len never wraps.
  assign last = (cnt == COUNT_W'(1));
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= 32'h0000_0000;
      x          <= 32'h0000_0000;
      cnt        <= '0;
      in_ack     <= 1'b0;
      add_a      <= 32'h0000_0000;
      add_a_stb  <= 1'b0;
      add_b      <= 32'h0000_0000;
      add_b_stb  <= 1'b0;
      add_z_ack  <= 1'b0;
      result     <= 32'h0000_0000;
      result_stb <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= 32'h0000_0000;
            cnt   <= len;
            state <= (len == '0) ? S_PUT_R : S_GET_X;
          end
        end
        S_GET_X: begin
          if (in_ack && in_stb) begin
            in_ack <= 1'b0;
`ifdef FP32_ACC_ZERO_SKIP_EN
            if (in_data[30:0] == 31'd0) begin
              cnt   <= cnt - COUNT_W'(1);
              state <= last ? S_PUT_R : S_GET_X;
            end else begin
              x     <= in_data;
              state <= S_SEND_A;
            end
`else
            x     <= in_data;
            state <= S_SEND_A;
`endif
          end else begin
            in_ack <= 1'b1;
          end
        end
        S_SEND_A: begin
          if (add_a_stb && add_a_ack) begin
            add_a_stb <= 1'b0;
            state     <= S_SEND_B;
          end else begin
            add_a     <= acc;
            add_a_stb <= 1'b1;
          end
        end
        S_SEND_B: begin
          if (add_b_stb && add_b_ack) begin
            add_b_stb <= 1'b0;
            state     <= S_GET_Z;
          end else begin
            add_b     <= x;
            add_b_stb <= 1'b1;
          end
        end
        S_GET_Z: begin
          if (add_z_ack && add_z_stb) begin
            acc       <= add_z;
            add_z_ack <= 1'b0;
            cnt       <= cnt - COUNT_W'(1);
            state     <= last ? S_PUT_R : S_GET_X;
          end else begin
            add_z_ack <= 1'b1;
          end
        end
        S_PUT_R: begin
          if (result_stb && result_ack) begin
            result_stb <= 1'b0;
            state      <= S_IDLE;
          end else begin
            result     <= acc;
            result_stb <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp32_accum_sequencer.sv
// tb/tb_fp32_accum_sequencer.sv - randomized bench for fp32_accum_sequencer with an integer-valued FP32 adder model
module tb_fp32_accum_sequencer;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] len;
  logic [31:0]   in_data;
  logic          in_stb;
  logic          in_ack;
  logic [31:0]   add_a;
  logic          add_a_stb;
  logic          add_a_ack;
  logic [31:0]   add_b;
  logic          add_b_stb;
  logic          add_b_ack;
  logic [31:0]   add_z;
  logic          add_z_stb;
  logic          add_z_ack;
  logic [31:0]   result;
  logic          result_stb;
  logic          result_ack;
  logic          busy;

  always #5 clk = ~clk;

  fp32_accum_sequencer #(.COUNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .in_data(in_data), .in_stb(in_stb), .in_ack(in_ack),
    .add_a(add_a), .add_a_stb(add_a_stb), .add_a_ack(add_a_ack),
    .add_b(add_b), .add_b_stb(add_b_stb), .add_b_ack(add_b_ack),
    .add_z(add_z), .add_z_stb(add_z_stb), .add_z_ack(add_z_ack),
    .result(result), .result_stb(result_stb), .result_ack(result_ack),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Integer-valued FP32 encode/decode; the bench only ever produces such values.
  function automatic logic [31:0] enc(input int v);
    logic [31:0] m;
    logic [31:0] r;
    int p;
    if (v == 0) return 32'h0;
    m = (v < 0) ? 32'(-v) : 32'(v);
    p = 0;
    for (int i = 0; i < 24; i++) if ((m >> i) != 0) p = i;
    r[31]    = (v < 0);
    r[30:23] = 8'(127 + p);
    r[22:0]  = 23'((m << (23 - p)) & 32'h007F_FFFF);
    return r;
  endfunction

  function automatic int dec(input logic [31:0] f);
    int p;
    int m;
    if (f[30:0] == 31'd0) return 0;
    p = int'(f[30:23]) - 127;
    m = int'({9'd1, f[22:0]} >> (23 - p));
    return f[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic a_inf, b_inf;
    a_inf = (a[30:0] == 31'h7F80_0000);
    b_inf = (b[30:0] == 31'h7F80_0000);
    if ((a[30:23] == 8'hFF && !a_inf) || (b[30:23] == 8'hFF && !b_inf)) return 32'hFFC0_0000;
    if (a_inf && b_inf && (a[31] != b[31])) return 32'hFFC0_0000;
    if (a_inf) return a;
    if (b_inf) return b;
    return enc(dec(a) + dec(b));
  endfunction

  function automatic int exp_exch(input logic [31:0] e[$], input int n);
    int c = 0;
    for (int i = 0; i < n; i++) begin
`ifdef FP32_ACC_ZERO_SKIP_EN
      if (e[i][30:0] != 31'd0) c++;
`else
      c++;
`endif
    end
    return c;
  endfunction

  logic [31:0] src_q[$];
  logic [31:0] sent_q[$];
  int          n_in, n_a, n_b, n_z, n_r, order_err, phase;
  logic [31:0] exp_acc, r_val, op_a, op_b;
  bit          in_x, a_x, b_x, z_x, r_x;
  bit          hold_res = 0;
  bit          hold_z = 0;

  // Transfer monitor: sees pre-edge values of both sides of every link.
  always @(posedge clk) begin
    if (!rst) begin
      if (in_stb && in_ack) begin
        in_x = 1; n_in++;
`ifdef FP32_ACC_ZERO_SKIP_EN
        if (in_data[30:0] != 31'd0) sent_q.push_back(in_data);
`else
        sent_q.push_back(in_data);
`endif
      end
      if (add_a_stb && add_a_ack) begin
        a_x = 1; n_a++; op_a = add_a;
        if (phase != 0) order_err++;
        phase = 1;
        chk("operand_a", add_a, exp_acc);
      end
      if (add_b_stb && add_b_ack) begin
        b_x = 1; n_b++; op_b = add_b;
        if (phase != 1) order_err++;
        phase = 2;
        if (sent_q.size() > 0) chk("operand_b", add_b, sent_q.pop_front());
        else order_err++;
      end
      if (add_z_stb && add_z_ack) begin
        z_x = 1; n_z++; exp_acc = add_z;
        if (phase != 2) order_err++;
        phase = 0;
      end
      if (result_stb && result_ack) begin
        r_x = 1; n_r++; r_val = result;
      end
    end
  end

  // Source, adder and consumer behaviour, all driven on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (in_x) begin
          in_x = 0; in_stb = 0;
          if (src_q.size() > 0) void'(src_q.pop_front());
        end
        if (!in_stb && src_q.size() > 0 && $urandom_range(0, 3) != 0) begin
          in_stb = 1; in_data = src_q[0];
        end
        if (a_x) begin a_x = 0; add_a_ack = 0; end
        else if (add_a_stb && !add_a_ack && $urandom_range(0, 1) == 1) add_a_ack = 1;
        if (b_x) begin b_x = 0; add_b_ack = 0; end
        else if (add_b_stb && !add_b_ack && $urandom_range(0, 1) == 1) add_b_ack = 1;
        if (z_x) begin z_x = 0; add_z_stb = 0; end
        else if (!add_z_stb && phase == 2 && !hold_z && $urandom_range(0, 2) == 0) begin
          add_z_stb = 1; add_z = fadd(op_a, op_b);
        end
        if (r_x) begin r_x = 0; result_ack = 0; end
        else if (result_stb && !result_ack && !hold_res && $urandom_range(0, 1) == 1) result_ack = 1;
      end
    end
  end

  task automatic clear_tb();
    in_stb = 0; add_a_ack = 0; add_b_ack = 0; add_z_stb = 0; result_ack = 0;
    in_x = 0; a_x = 0; b_x = 0; z_x = 0; r_x = 0;
    src_q.delete(); sent_q.delete();
    phase = 0; exp_acc = 32'h0;
  endtask

  task automatic arm(input int n_len, input logic [31:0] elems[$]);
    @(posedge clk); #1;
    in_stb = 0;
    src_q = elems;
    src_q.push_back(enc(7));
    src_q.push_back(enc(9));
    sent_q.delete();
    n_in = 0; n_a = 0; n_b = 0; n_z = 0; n_r = 0; order_err = 0; phase = 0;
    exp_acc = 32'h0;
    start = 1; len = CW'(n_len);
    @(posedge clk); #1;
    start = 0; len = CW'($urandom);
  endtask

  task automatic wait_result(input string tag);
    for (int i = 0; i < 4000 && n_r == 0; i++) begin
      @(posedge clk); #1;
    end
    if (n_r == 0) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run(input string tag, input int n_len, input logic [31:0] elems[$],
                     input logic [31:0] exp_res);
    int ex;
    ex = exp_exch(elems, n_len);
    arm(n_len, elems);
    wait_result(tag);
    chk({tag, "_result"}, r_val, exp_res);
    chk({tag, "_a_count"}, 32'(n_a), 32'(ex));
    chk({tag, "_z_count"}, 32'(n_z), 32'(ex));
    chk({tag, "_in_count"}, 32'(n_in), 32'(n_len));
    chk({tag, "_order"}, 32'(order_err), 32'd0);
    chk({tag, "_left_in_src"}, 32'(src_q.size()), 32'd2);
    chk({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
  endtask

  logic [31:0] q[$];
  int          sum;
  int          v;
  int          n;

  initial begin
    rst = 1; start = 0; len = '0; in_data = 32'h0;
    clear_tb();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_flags", {26'd0, in_ack, add_a_stb, add_b_stb, add_z_ack, result_stb, busy}, 32'd0);
    chk("reset_result", result, 32'h0);
    chk("reset_add_a", add_a, 32'h0);
    rst = 0;

    q.delete(); q.push_back(32'h3F80_0000); q.push_back(32'h4000_0000); q.push_back(32'h4040_0000);
    run("sum123", 3, q, 32'h40C0_0000);

    q.delete();
    run("len0", 0, q, 32'h0000_0000);

    q.delete(); q.push_back(32'h7F80_0000); q.push_back(32'hFF80_0000);
    run("inf_minus_inf", 2, q, 32'hFFC0_0000);
    q.push_back(32'h3F80_0000);
    run("nan_propagate", 3, q, 32'hFFC0_0000);

    q.delete(); q.push_back(32'h3F80_0000); q.push_back(32'h8000_0000); q.push_back(32'h3F80_0000);
    run("zero_elem", 3, q, 32'h4000_0000);

    q.delete();
    for (int i = 0; i < 15; i++) q.push_back(32'h3F80_0000);
    run("max_len", 15, q, enc(15));

    // Consumer stalls: sum must sit still on the output until accepted.
    hold_res = 1;
    q.delete(); q.push_back(enc(3));
    arm(1, q);
    for (int i = 0; i < 200 && !result_stb; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 10; i++) begin
      chk("hold_stb", {31'd0, result_stb}, 32'd1);
      chk("hold_result", result, enc(3));
      chk("hold_busy", {31'd0, busy}, 32'd1);
      @(posedge clk); #1;
    end
    hold_res = 0;
    wait_result("hold");
    chk("hold_final", r_val, enc(3));
    chk("hold_idle", {31'd0, busy}, 32'd0);

    // Reset while the sequencer waits on the adder result.
    hold_z = 1;
    q.delete(); q.push_back(enc(1)); q.push_back(enc(2)); q.push_back(enc(3));
    arm(3, q);
    for (int i = 0; i < 200 && phase != 2; i++) begin
      @(posedge clk); #1;
    end
    chk("midrst_reached_z", 32'(phase), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk); #1;
    chk("midrst_flags", {26'd0, in_ack, add_a_stb, add_b_stb, add_z_ack, result_stb, busy}, 32'd0);
    clear_tb();
    hold_z = 0;
    rst = 0;
    q.delete(); q.push_back(enc(5)); q.push_back(enc(6));
    run("after_rst", 2, q, enc(11));

    for (int r = 0; r < 12; r++) begin
      n = int'($urandom_range(0, 7));
      q.delete(); sum = 0;
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          q.push_back(($urandom_range(0, 1) == 1) ? 32'h8000_0000 : 32'h0);
        end else begin
          v = int'($urandom_range(0, 1000)) - 500;
          sum += v;
          q.push_back(enc(v));
        end
      end
      run($sformatf("rand%0d", r), n, q, enc(sum));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
